uart_tx_cfg: RTL

Configurable, buffered UART transmitter; the next-generation replacement for the fixed 8N1 transmitter on the UART serial line. Adds a parameterised data width, runtime-selectable parity and stop-bit count, and a small transmit FIFO so the host can queue several characters without waiting for each frame. It drives the same serial line consumed by the UART receiver and keeps the same CLKS_PER_BIT bit-timing scheme.

---
 rtl/uart_tx_cfg.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: buffered UART transmitter with a configurable frame format.
// Characters are queued in a small FIFO and sent as: start bit, DATA_BITS
// data bits LSB first, optional parity bit, then one or two stop bits.
// Parity mode and stop-bit count are sampled when a character leaves the
// FIFO, so changing them mid-frame only affects later frames.
//
// Ports:
//   i_Clock        system clock, rising edge
//   i_Rst_L        asynchronous active-low reset
//   i_TX_DV        write strobe, taken only while o_TX_Ready is high
//   i_TX_Byte      character to enqueue
//   i_Parity_Mode  00 none, 01 even, 10 odd, 11 none
//   i_Two_Stop     0 one stop bit, 1 two stop bits
//   o_TX_Ready     FIFO not full
//   o_FIFO_Count   queued entries, excluding the frame being sent
//   o_TX_Active    high from the first start-bit cycle to the last stop-bit cycle
//   o_TX_Serial    serial line, idle high
//   o_TX_Done      one-cycle pulse in the idle cycle after each frame
//   o_Overflow     one-cycle pulse the cycle after a strobe hit a full FIFO
//
// state  | meaning
// IDLE   | line high; pops the FIFO head when one is queued
// START  | drive start bit (0)
// DATA   | drive data bits LSB first
// PARITY | drive parity bit (only when parity enabled)
// STOP   | drive one or two stop bits (1)
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic                          i_TX_DV,
  input  logic [DATA_BITS-1:0]          i_TX_Byte,
  input  logic [1:0]                    i_Parity_Mode,
  input  logic                          i_Two_Stop,
  output logic                          o_TX_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_TX_Active,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Done,
  output logic                          o_Overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ONE     = (PTR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e state_q, state_d;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q, count_d;
  logic                 push, pop;

  // Frame datapath
  logic [DATA_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_idx_q;
  logic                 par_en_q, par_bit_q, two_stop_q;
  logic                 bit_end;

  logic                 done_q, done_d;
  logic                 overflow_q;

  // Ready is based on the registered count only, so a same-cycle pop never
  // lets a full FIFO accept a push.
  assign o_TX_Ready   = (count_q != FULL);
  assign o_FIFO_Count = count_q;
  assign push         = i_TX_DV && o_TX_Ready;
  assign pop          = (state_q == S_IDLE) && (count_q != '0);
  assign bit_end      = (cnt_q == CNT_MAX);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_TX_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= i_TX_DV && !o_TX_Ready;
      done_q     <= done_d;
    end
  end

  // State register
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Bit timing, shift register and per-frame configuration
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (pop) begin
      shift_q    <= mem_q[rd_ptr_q];
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      par_en_q   <= (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
      par_bit_q  <= (^mem_q[rd_ptr_q]) ^ (i_Parity_Mode == 2'b10);
      two_stop_q <= i_Two_Stop;
    end else if (state_q != S_IDLE) begin
      if (bit_end) begin
        cnt_q <= '0;
        if (state_q == S_DATA) begin
          shift_q <= shift_q >> 1;
          idx_q   <= idx_q + 1'b1;
        end
        if (state_q == S_STOP) stop_idx_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE:   if (count_q != '0) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && (idx_q == IDX_MAX))
                  state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end && (!two_stop_q || stop_idx_q)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state so the line returns high as
  // soon as reset asserts.
  always_comb begin
    o_TX_Serial = 1'b1;
    o_TX_Active = 1'b1;
    unique case (state_q)
      S_IDLE:   o_TX_Active = 1'b0;
      S_START:  o_TX_Serial = 1'b0;
      S_DATA:   o_TX_Serial = shift_q[0];
      S_PARITY: o_TX_Serial = par_bit_q;
      S_STOP:   o_TX_Serial = 1'b1;
      default: begin
        o_TX_Serial = 1'b1;
        o_TX_Active = 1'b0;
      end
    endcase
  end

  assign o_TX_Done  = done_q;
  assign o_Overflow = overflow_q;

endmodule
